// File: rtl/stepgen_ctrl_pkg.sv
// Shared definitions for the step generator host controller: register map
// helpers and CONTROL/status bit positions.
package stepgen_ctrl_pkg;

  localparam int CTRL_RUN     = 0;
  localparam int CTRL_CLRBITE = 1;

  localparam int STAT_ENABLE  = 0;
  localparam int STAT_BITE    = 1;

  // Per-channel velocity bytes occupy 0 .. 2*ch-1; shared registers follow.
  function automatic int addr_dirtime(input int ch);
    return 2 * ch;
  endfunction

  function automatic int addr_steptime(input int ch);
    return 2 * ch + 1;
  endfunction

  function automatic int addr_control(input int ch);
    return 2 * ch + 2;
  endfunction

endpackage

// File: rtl/stepgen_watchdog.sv
// Commit watchdog: reloads on every commit, counts wd_tick while enabled,
// and bites (drops enable) when the count runs out.
module stepgen_watchdog #(
  parameter int            WD      = 8,
  parameter logic [WD-1:0] WD_LOAD = 8'd200
) (
  input  logic clk,
  input  logic rst_n,
  input  logic commit,
  input  logic run_req,
  input  logic clr_bite,
  input  logic wd_tick,
  output logic enable,
  output logic wd_bite,
  output logic expire
);

  logic [WD-1:0] count_q, count_d;
  logic          bite_q, bite_d;
  logic          en_q, en_d;

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no path through the block can infer a latch.
  always_comb begin
    count_d = count_q;
    bite_d  = bite_q;
    en_d    = en_q;
    expire  = 1'b0;
    if (commit) begin
      // A commit overrides any tick arriving on the same edge.
      count_d = WD_LOAD;
      bite_d  = bite_q & ~clr_bite;
      en_d    = run_req & ~bite_d;
    end else if (en_q && wd_tick && (count_q != '0)) begin
      if (count_q == WD'(1)) begin
        count_d = '0;
        bite_d  = 1'b1;
        en_d    = 1'b0;
        expire  = 1'b1;
      end else begin
        count_d = count_q - WD'(1);
      end
    end
  end

  // NOTE: state registers use non-blocking '<=' so every flop samples the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      bite_q  <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      bite_q  <= bite_d;
      en_q    <= en_d;
    end
  end

  assign enable  = en_q;
  assign wd_bite = bite_q;

endmodule

// File: rtl/stepgen_ctrl.sv
// Host-facing controller for CH step generators: byte-wide shadow registers,
// atomic commit, coherent position snapshot readback and a commit watchdog.
module stepgen_ctrl
  import stepgen_ctrl_pkg::*;
#(
  parameter int            CH      = 4,
  parameter int            W       = 12,
  parameter int            F       = 10,
  parameter int            T       = 5,
  parameter int            A       = 4,
  parameter int            WD      = 8,
  parameter logic [WD-1:0] WD_LOAD = 8'd200
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [A-1:0]          addr,
  input  logic [7:0]            wdata,
  output logic [7:0]            rdata,
  input  logic                  wd_tick,
  input  logic [CH*(W+F)-1:0]   position,
  output logic [CH*(F+1)-1:0]   velocity,
  output logic [T-1:0]          dirtime,
  output logic [T-1:0]          steptime,
  output logic                  enable
);

  localparam logic [A-1:0] ADDR_DT   = A'(addr_dirtime(CH));
  localparam logic [A-1:0] ADDR_ST   = A'(addr_steptime(CH));
  localparam logic [A-1:0] ADDR_CTRL = A'(addr_control(CH));

  typedef logic [F:0] vel_t;

  vel_t          vel_sh_q [CH], vel_sh_d [CH];
  vel_t          vel_q    [CH], vel_d    [CH];
  logic [T-1:0]  dt_sh_q, dt_sh_d, st_sh_q, st_sh_d;
  logic [T-1:0]  dt_q, dt_d, st_q, st_d;
  logic [W-1:0]  snap_q   [CH], snap_d   [CH];
  logic [15:0]   snap_ext [CH];
  logic [7:0]    rdata_q, rdata_d;
  logic          commit, wd_bite, expire;

  assign commit = wr && (addr == ADDR_CTRL);

  stepgen_watchdog #(.WD(WD), .WD_LOAD(WD_LOAD)) u_wd (
    .clk      (clk),
    .rst_n    (rst_n),
    .commit   (commit),
    .run_req  (wdata[CTRL_RUN]),
    .clr_bite (wdata[CTRL_CLRBITE]),
    .wd_tick  (wd_tick),
    .enable   (enable),
    .wd_bite  (wd_bite),
    .expire   (expire)
  );

  // Readback only needs the integer part, widened to 16 bits for two bytes.
  for (genvar c = 0; c < CH; c++) begin : g_ext
    if (W < 16) begin : g_sx
      assign snap_ext[c] = {{(16 - W){snap_q[c][W-1]}}, snap_q[c]};
    end else begin : g_tr
      assign snap_ext[c] = snap_q[c][15:0];
    end
  end

  always_comb begin
    vel_sh_d = vel_sh_q;
    dt_sh_d  = dt_sh_q;
    st_sh_d  = st_sh_q;
    vel_d    = vel_q;
    dt_d     = dt_q;
    st_d     = st_q;
    snap_d   = snap_q;

    if (wr) begin
      for (int c = 0; c < CH; c++) begin
        if (addr == A'(2 * c))     vel_sh_d[c][7:0] = wdata;
        if (addr == A'(2 * c + 1)) vel_sh_d[c][F:8] = wdata[F-8:0];
      end
      if (addr == ADDR_DT) dt_sh_d = wdata[T-1:0];
      if (addr == ADDR_ST) st_sh_d = wdata[T-1:0];
    end

    if (commit) begin
      vel_d = vel_sh_q;
      dt_d  = dt_sh_q;
      st_d  = st_sh_q;
      for (int c = 0; c < CH; c++) snap_d[c] = position[c*(W+F)+F +: W];
    end else if (expire) begin
      for (int c = 0; c < CH; c++) vel_d[c] = '0;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (rd) begin
      rdata_d = '0;
      for (int c = 0; c < CH; c++) begin
        if (addr == A'(2 * c))     rdata_d = snap_ext[c][7:0];
        if (addr == A'(2 * c + 1)) rdata_d = snap_ext[c][15:8];
      end
      if (addr == ADDR_CTRL) begin
        rdata_d[STAT_ENABLE] = enable;
        rdata_d[STAT_BITE]   = wd_bite;
      end
    end
  end

  // NOTE: the register arrays are reset like any other flop because their
  // contents reach the outputs and readback directly; they are not RAMs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < CH; c++) begin
        vel_sh_q[c] <= '0;
        vel_q[c]    <= '0;
        snap_q[c]   <= '0;
      end
      dt_sh_q <= '0;
      st_sh_q <= '0;
      dt_q    <= '0;
      st_q    <= '0;
      rdata_q <= '0;
    end else begin
      vel_sh_q <= vel_sh_d;
      vel_q    <= vel_d;
      snap_q   <= snap_d;
      dt_sh_q  <= dt_sh_d;
      st_sh_q  <= st_sh_d;
      dt_q     <= dt_d;
      st_q     <= st_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    velocity = '0;
    for (int c = 0; c < CH; c++) velocity[c*(F+1) +: F+1] = vel_q[c];
  end

  assign dirtime  = dt_q;
  assign steptime = st_q;
  assign rdata    = rdata_q;

endmodule
